day_name_scroller: RTL and testbench

//   Drives a multiplexed multi-digit 7-segment display with the 3-letter name of
//   the current weekday (MON..SUN). The day advances automatically after a

---
 rtl/day_disp_pkg.sv | 59 +++++
 rtl/tick_gen.sv | 34 +++
 rtl/day_name_scroller.sv | 88 ++++++++
 tb/tb_day_name_scroller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/day_disp_pkg.sv
// Shared definitions for the weekday-name 7-segment display.
//   - 3-bit day encoding MON..SUN
//   - 7-segment glyphs {A,B,C,D,E,F,G} (bit 6 = A, 1 = lit) for every letter used
//   - day_glyph(day, pos): glyph of letter pos (0..2) of the day name, 0 for pos >= 3
//   - cnt_w(n): counter width for a modulo-n counter, never less than 1 bit
package day_disp_pkg;

  localparam logic [2:0] MON = 3'd0;
  localparam logic [2:0] TUE = 3'd1;
  localparam logic [2:0] WED = 3'd2;
  localparam logic [2:0] THU = 3'd3;
  localparam logic [2:0] FRI = 3'd4;
  localparam logic [2:0] SAT = 3'd5;
  localparam logic [2:0] SUN = 3'd6;

  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;
  localparam logic [6:0] GLYPH_H = 7'b0110111;
  localparam logic [6:0] GLYPH_I = 7'b0110000;
  localparam logic [6:0] GLYPH_M = 7'b1100110;
  localparam logic [6:0] GLYPH_N = 7'b0010101;
  localparam logic [6:0] GLYPH_O = 7'b1111110;
  localparam logic [6:0] GLYPH_R = 7'b0000101;
  localparam logic [6:0] GLYPH_S = 7'b1011011;
  localparam logic [6:0] GLYPH_T = 7'b1110000;
  localparam logic [6:0] GLYPH_U = 7'b0111110;
  localparam logic [6:0] GLYPH_W = 7'b0001110;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [6:0] day_glyph(input logic [2:0] day_val, input int unsigned pos);
    // Three glyphs packed left letter first.
    logic [20:0] name;
    // NOTE: every variable assigned in combinational code gets a default first,
    // otherwise an unlisted case leaves it holding its old value (a latch).
    name = '0;
    case (day_val)
      MON:     name = {GLYPH_M, GLYPH_O, GLYPH_N};
      TUE:     name = {GLYPH_T, GLYPH_U, GLYPH_E};
      WED:     name = {GLYPH_W, GLYPH_E, GLYPH_D};
      THU:     name = {GLYPH_T, GLYPH_H, GLYPH_U};
      FRI:     name = {GLYPH_F, GLYPH_R, GLYPH_I};
      SAT:     name = {GLYPH_S, GLYPH_A, GLYPH_T};
      SUN:     name = {GLYPH_S, GLYPH_U, GLYPH_N};
      default: name = '0;
    endcase
    case (pos)
      0:       return name[20:14];
      1:       return name[13:7];
      2:       return name[6:0];
      default: return 7'b0;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter with synchronous clear and count enable.
//   clk  posedge clock
//   rst  synchronous active-high reset (count -> 0)
//   clr  synchronous clear, wins over en
//   en   count enable
//   tc   terminal count: high while the count equals N-1
module tick_gen
  import day_disp_pkg::*;
#(
  parameter int N = 4,
  localparam int W = cnt_w(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/day_name_scroller.sv
// Shows the 3-letter weekday name on a multiplexed DIGITS-digit 7-segment display.
// The day advances after DWELL_CYCLES enabled cycles (auto mode) or on a step pulse.
//   clk       posedge clock
//   rst       synchronous active-high reset
//   en        1 = day and dwell run; 0 = frozen (scanning continues)
//   mode      0 = auto (dwell or step), 1 = manual (step only)
//   step      advance request
//   seg       segments {A..G}, seg[6] = A, 1 = lit, registered
//   an        one-hot digit select, an[0] = leftmost, registered
//   day       current day 0 = MON .. 6 = SUN, registered
//   day_wrap  one-cycle pulse alongside the SUN -> MON change
module day_name_scroller
  import day_disp_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 4,
  parameter int SCAN_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              step,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [2:0]        day,
  output logic              day_wrap
);

  localparam int IW = cnt_w(DIGITS);

  logic          mode_q;
  logic          mode_chg;
  logic          dwell_tc;
  logic          scan_tc;
  logic          adv;
  logic [IW-1:0] scan_idx;

  // The first cycle after a mode switch restarts the dwell and cannot expire it.
  assign mode_chg = mode ^ mode_q;
  assign adv      = en & (step | (~mode & ~mode_chg & dwell_tc));

  // Dwell divider: held at zero in manual mode, restarted by every advance.
  tick_gen #(.N(DWELL_CYCLES)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (mode | mode_chg | adv),
    .en  (en),
    .tc  (dwell_tc)
  );

  // Scan divider: free-running, independent of en and mode.
  tick_gen #(.N(SCAN_CYCLES)) u_scan (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (1'b1),
    .tc  (scan_tc)
  );

  // mode_q only detects edges on mode, so it tracks the input even during reset
  // and a reset never looks like a mode change.
  always_ff @(posedge clk) begin
    mode_q <= mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day      <= MON;
      day_wrap <= 1'b0;
      scan_idx <= '0;
      seg      <= '0;
      an       <= '0;
    end else begin
      day_wrap <= adv && (day == SUN);
      if (adv) begin
        day <= (day == SUN) ? MON : day + 3'd1;
      end
      if (scan_tc) begin
        scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end
      // Outputs follow the current state with one cycle of latency.
      an  <= DIGITS'(1) << scan_idx;
      seg <= day_glyph(day, 32'(scan_idx));
    end
  end

endmodule

// File: tb/tb_day_name_scroller.sv
// Self-checking bench for day_name_scroller (DIGITS=4, DWELL_CYCLES=4, SCAN_CYCLES=2).
// Expected outputs come from a hand-written vector table and from a small
// behavioural model; both feed a scoreboard queue that is drained after each edge.
module tb_day_name_scroller;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int SCAN   = 2;

  logic              clk = 1'b0;
  logic              rst, en, mode, step;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic [2:0]        day;
  logic              day_wrap;

  always #5 clk = ~clk;

  day_name_scroller #(
    .DIGITS(DIGITS), .DWELL_CYCLES(DWELL), .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
    .seg(seg), .an(an), .day(day), .day_wrap(day_wrap)
  );

  typedef struct {
    logic [2:0]        day;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              wrap;
  } exp_t;

  typedef struct {
    logic rst, en, mode, step;
    exp_t e;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Reference model state (post-edge register contents).
  int   m_day = 0, m_dwell = 0, m_idx = 0, m_cnt = 0;
  logic m_mode_q = 1'b0;

  localparam logic [6:0] L_M = 7'b1100110, L_O = 7'b1111110, L_N = 7'b0010101,
                         L_E = 7'b1001111, L_W = 7'b0001110;

  function automatic logic [6:0] letter(input byte c);
    case (c)
      "M": return 7'b1100110;  "T": return 7'b1110000;  "W": return 7'b0001110;
      "F": return 7'b1000111;  "S": return 7'b1011011;  "O": return 7'b1111110;
      "N": return 7'b0010101;  "U": return 7'b0111110;  "E": return 7'b1001111;
      "D": return 7'b0111101;  "H": return 7'b0110111;  "R": return 7'b0000101;
      "I": return 7'b0110000;  "A": return 7'b1110111;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [6:0] ref_glyph(input int d, input int pos);
    string nm;
    case (d)
      0: nm = "MON"; 1: nm = "TUE"; 2: nm = "WED"; 3: nm = "THU";
      4: nm = "FRI"; 5: nm = "SAT"; default: nm = "SUN";
    endcase
    if (pos >= 3) return 7'b0;
    return letter(nm[pos]);
  endfunction

  task automatic model(input logic r, e, md, st, output exp_t x);
    bit chg, adv;
    x.day = 3'd0; x.an = '0; x.seg = '0; x.wrap = 1'b0;
    if (r) begin
      m_day = 0; m_dwell = 0; m_idx = 0; m_cnt = 0;
    end else begin
      chg    = (md != m_mode_q);
      adv    = e && (st || (!md && !chg && m_dwell == DWELL - 1));
      x.an   = DIGITS'(1 << m_idx);
      x.seg  = ref_glyph(m_day, m_idx);
      x.wrap = adv && (m_day == 6);
      if (adv) m_day = (m_day + 1) % 7;
      if (md || chg || adv) m_dwell = 0;
      else if (e) m_dwell++;
      if (m_cnt == SCAN - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_cnt++;
      end
      x.day = 3'(m_day);
    end
    m_mode_q = md;
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    x = exp_q.pop_front();
    if (day === x.day && an === x.an && seg === x.seg && day_wrap === x.wrap) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got day=%0d an=%b seg=%b wrap=%b, want day=%0d an=%b seg=%b wrap=%b",
               tag, day, an, seg, day_wrap, x.day, x.an, x.seg, x.wrap);
    end
  endtask

  task automatic chk_val(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  // Drive one cycle; expected values come from the model.
  task automatic cyc(input logic r, e, md, st, input string tag);
    exp_t x;
    rst = r; en = e; mode = md; step = st;
    model(r, e, md, st, x);
    exp_q.push_back(x);
    @(posedge clk); #1;
    check_out(tag);
  endtask

  function automatic exp_t mk(input int d, input logic [DIGITS-1:0] a,
                              input logic [6:0] s, input logic w);
    exp_t x;
    x.day = 3'(d); x.an = a; x.seg = s; x.wrap = w;
    return x;
  endfunction

  vec_t vecs[20];
  int   wraps, wrap_at;
  bit   found;

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; step = 1'b0;

    // Reset, first display, first dwell advance, then scan pattern with day frozen.
    vecs[0]  = '{1, 1, 0, 0, mk(0, 4'b0000, 7'b0, 0)};
    vecs[1]  = '{1, 1, 0, 0, mk(0, 4'b0000, 7'b0, 0)};
    vecs[2]  = '{0, 1, 0, 0, mk(0, 4'b0001, L_M, 0)};
    vecs[3]  = '{0, 1, 0, 0, mk(0, 4'b0001, L_M, 0)};
    vecs[4]  = '{0, 1, 0, 0, mk(0, 4'b0010, L_O, 0)};
    vecs[5]  = '{0, 1, 0, 0, mk(1, 4'b0010, L_O, 0)};
    vecs[6]  = '{0, 1, 0, 0, mk(1, 4'b0100, L_E, 0)};
    vecs[7]  = '{0, 1, 0, 0, mk(1, 4'b0100, L_E, 0)};
    vecs[8]  = '{0, 1, 0, 0, mk(1, 4'b1000, 7'b0, 0)};
    vecs[9]  = '{0, 1, 0, 0, mk(2, 4'b1000, 7'b0, 0)};
    vecs[10] = '{0, 1, 0, 0, mk(2, 4'b0001, L_W, 0)};
    vecs[11] = '{1, 0, 0, 0, mk(0, 4'b0000, 7'b0, 0)};
    vecs[12] = '{0, 0, 0, 0, mk(0, 4'b0001, L_M, 0)};
    vecs[13] = '{0, 0, 0, 0, mk(0, 4'b0001, L_M, 0)};
    vecs[14] = '{0, 0, 0, 0, mk(0, 4'b0010, L_O, 0)};
    vecs[15] = '{0, 0, 0, 0, mk(0, 4'b0010, L_O, 0)};
    vecs[16] = '{0, 0, 0, 0, mk(0, 4'b0100, L_N, 0)};
    vecs[17] = '{0, 0, 0, 0, mk(0, 4'b0100, L_N, 0)};
    vecs[18] = '{0, 0, 0, 1, mk(0, 4'b1000, 7'b0, 0)};
    vecs[19] = '{0, 0, 0, 0, mk(0, 4'b1000, 7'b0, 0)};

    for (int i = 0; i < 20; i++) begin
      exp_t dummy;
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode; step = vecs[i].step;
      model(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].step, dummy);
      exp_q.push_back(vecs[i].e);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i));
    end

    // Auto run through a whole week: one wrap pulse, on the return to MON.
    cyc(1, 1, 0, 0, "week_rst");
    wraps = 0; wrap_at = -1;
    for (int i = 1; i <= 28; i++) begin
      cyc(0, 1, 0, 0, "week");
      if (day_wrap) begin wraps++; wrap_at = i; end
      if (i % 4 == 0) chk_val($sformatf("week_day_c%0d", i), day, (i / 4) % 7);
    end
    chk_val("wrap_count", wraps, 1);
    chk_val("wrap_cycle", wrap_at, 28);

    // Manual mode: advances only on step; en=0 blocks step.
    cyc(1, 1, 1, 0, "man_rst");
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 9; k++) cyc(0, 1, 1, 0, "man_idle");
      chk_val($sformatf("man_before%0d", p), day, p);
      cyc(0, 1, 1, 1, "man_step");
      chk_val($sformatf("man_after%0d", p), day, p + 1);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, "man_en0");
    chk_val("man_en0_hold", day, 3);
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0, "man_nodwell");
    chk_val("man_no_dwell", day, 3);

    // Back to auto: the switch cycle restarts the dwell.
    cyc(0, 1, 0, 0, "mode_back");
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, "mode_back_run");
    chk_val("mode_back_hold", day, 3);
    cyc(0, 1, 0, 0, "mode_back_adv");
    chk_val("mode_back_adv", day, 4);

    // Step coinciding with dwell expiry: one increment, dwell restarts.
    cyc(1, 1, 0, 0, "coin_rst");
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, "coin_pre");
    cyc(0, 1, 0, 1, "coin_hit");
    chk_val("coin_single", day, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, "coin_post");
    chk_val("coin_hold", day, 1);
    cyc(0, 1, 0, 0, "coin_next");
    chk_val("coin_next", day, 2);

    // Reset mid-run at day=5, scan_idx=2.
    cyc(1, 1, 0, 0, "mid_rst0");
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      cyc(0, 1, 0, 0, "mid_run");
      found = (m_day == 5 && m_idx == 2);
    end
    chk_val("mid_reach", int'(found), 1);
    chk_val("mid_day5", day, 5);
    cyc(1, 1, 0, 1, "mid_rst");
    chk_val("mid_rst_day", day, 0);
    chk_val("mid_rst_an", an, 0);
    chk_val("mid_rst_seg", seg, 0);
    chk_val("mid_rst_wrap", day_wrap, 0);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, "mid_resume");
    chk_val("mid_resume_day", day, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
